// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous memory.
// One transaction per two cycles: a combinational grant in IDLE, then one response cycle.
module mem_arbiter #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          f_req,
   input  logic [63:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic          f_err,
   output logic [63:0]   f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [63:0]   d_addr,
   input  logic [63:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic          d_err,
   output logic [63:0]   d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [63:0]   mem_wdata,
   input  logic [63:0]   mem_rdata,
   output logic [7:0]    err_count
);

   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_F = 2'd1,
      RESP_D = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          last_d_q, last_d_d;
   logic          f_rvalid_q, f_rvalid_d;
   logic          f_err_q, f_err_d;
   logic          d_rvalid_q, d_rvalid_d;
   logic          d_err_q, d_err_d;
   logic          d_wr_q, d_wr_d;
   logic [CW-1:0] err_count_q, err_count_d;

   logic          f_legal, d_legal;
   logic [CW-1:0] err_count_inc;

   assign f_legal       = (f_addr < 64'(DEPTH));
   assign d_legal       = (d_addr < 64'(DEPTH));
   assign err_count_inc = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CW'(1);

   // Grant, memory strobes and next-state; last_d_q=1 means the data port won last.
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      f_rvalid_d  = 1'b0;
      f_err_d     = 1'b0;
      d_rvalid_d  = 1'b0;
      d_err_d     = 1'b0;
      d_wr_d      = 1'b0;
      err_count_d = err_count_q;
      f_gnt       = 1'b0;
      d_gnt       = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      unique case (state_q)
         IDLE: begin
            if (reset_n) begin
               if (d_req && (!f_req || !last_d_q)) begin
                  d_gnt = 1'b1;
               end else if (f_req) begin
                  f_gnt = 1'b1;
               end
            end
         end
         RESP_F, RESP_D: state_d = IDLE;
         default:        state_d = IDLE;
      endcase

      if (f_gnt) begin
         state_d    = RESP_F;
         last_d_d   = 1'b0;
         f_rvalid_d = 1'b1;
         f_err_d    = !f_legal;
         if (f_legal) begin
            mem_en    = 1'b1;
            mem_addr  = f_addr[AW-1:0];
            mem_wdata = d_wdata;
         end else begin
            err_count_d = err_count_inc;
         end
      end

      if (d_gnt) begin
         state_d    = RESP_D;
         last_d_d   = 1'b1;
         d_rvalid_d = 1'b1;
         d_err_d    = !d_legal;
         d_wr_d     = d_we;
         if (d_legal) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[AW-1:0];
            mem_wdata = d_wdata;
         end else begin
            err_count_d = err_count_inc;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         f_rvalid_q  <= 1'b0;
         f_err_q     <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_err_q     <= 1'b0;
         d_wr_q      <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         f_rvalid_q  <= f_rvalid_d;
         f_err_q     <= f_err_d;
         d_rvalid_q  <= d_rvalid_d;
         d_err_q     <= d_err_d;
         d_wr_q      <= d_wr_d;
         err_count_q <= err_count_d;
      end
   end

   // mem_rdata is already the memory's output register; gate it with the registered flags
   assign f_rvalid  = f_rvalid_q;
   assign f_err     = f_err_q;
   assign f_rdata   = (f_rvalid_q && !f_err_q) ? mem_rdata : '0;
   assign d_rvalid  = d_rvalid_q;
   assign d_err     = d_err_q;
   assign d_rdata   = (d_rvalid_q && !d_err_q && !d_wr_q) ? mem_rdata : '0;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and arbitration model.
module tb_mem_arbiter;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 10;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          f_req, f_gnt, f_rvalid, f_err;
   logic [63:0]   f_addr, f_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [63:0]   d_addr, d_wdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_wdata;
   logic [63:0]   mem_rdata = '0;
   logic [7:0]    err_count;

   typedef struct {
      bit          is_d;
      bit          err;
      logic [63:0] data;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   logic [63:0] tb_mem [DEPTH];
   logic [63:0] ref_mem[DEPTH];
   bit          m_last_d;
   int          m_errcnt;

   mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock(clock), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_err(f_err), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_count(err_count)
   );

   always #5 clock = ~clock;

   // Synchronous memory the arbiter drives
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response appears
   always @(negedge clock) begin
      if (reset_n) begin
         chk("rvalid_excl", 64'(f_rvalid & d_rvalid), 64'd0);
         if (f_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got f_rvalid=%0b d_rvalid=%0b want none", f_rvalid, d_rvalid);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_port", 64'(d_rvalid), 64'(mon_e.is_d));
               chk("resp_err", 64'(mon_e.is_d ? d_err : f_err), 64'(mon_e.err));
               chk("resp_data", mon_e.is_d ? d_rdata : f_rdata, mon_e.data);
               chk("err_count", 64'(err_count), 64'(mon_e.cnt));
            end
         end else begin
            chk("idle_rdata", f_rdata | d_rdata, 64'd0);
            chk("idle_err", 64'({f_err, d_err}), 64'd0);
         end
      end
   end

   function automatic logic [63:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0:       return 64'(DEPTH) + 64'($urandom_range(0, 100));
         1:       return {32'($urandom), 32'($urandom)};
         2:       return 64'(DEPTH - 1);
         default: return 64'($urandom_range(0, 15));
      endcase
   endfunction

   // Issue one request pattern starting at a negedge in IDLE; ends at a negedge back in IDLE
   task automatic run_round(input bit fr, input bit dr, input logic [63:0] fa,
                            input logic [63:0] da, input bit we, input logic [63:0] wd);
      bit          pf, pd, win_d, legal;
      logic [63:0] addr;
      exp_t        e;
      f_req = fr; f_addr = fa;
      d_req = dr; d_addr = da; d_we = we; d_wdata = wd;
      pf = fr; pd = dr;
      while (pf || pd) begin
         #1;
         win_d = pd && (!pf || !m_last_d);
         chk("f_gnt", 64'(f_gnt), 64'(!win_d));
         chk("d_gnt", 64'(d_gnt), 64'(win_d));
         chk("gnt_vs_rvalid", 64'({f_rvalid, d_rvalid}), 64'd0);
         addr  = win_d ? da : fa;
         legal = (addr < 64'(DEPTH));
         chk("mem_en", 64'(mem_en), 64'(legal));
         chk("mem_we", 64'(mem_we), 64'(legal && win_d && we));
         if (legal) chk("mem_addr", 64'(mem_addr), 64'(addr[AW-1:0]));
         if (legal && win_d && we) chk("mem_wdata", mem_wdata, wd);
         e.is_d = win_d;
         e.err  = !legal;
         e.data = '0;
         if (!legal) begin
            if (m_errcnt < 255) m_errcnt++;
         end else if (win_d && we) begin
            ref_mem[addr[AW-1:0]] = wd;
         end else begin
            e.data = ref_mem[addr[AW-1:0]];
         end
         e.cnt = 8'(m_errcnt);
         sb.push_back(e);
         m_last_d = win_d;
         @(posedge clock);
         #1;
         if (win_d) begin d_req = 1'b0; pd = 1'b0; end
         else       begin f_req = 1'b0; pf = 1'b0; end
         @(negedge clock);
         #1;
         chk("busy_gnt", 64'({f_gnt, d_gnt}), 64'd0);
         @(negedge clock);
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         tb_mem[i]  = {32'($urandom), 32'($urandom)};
         ref_mem[i] = tb_mem[i];
      end
      tb_mem[5]  = 64'd12;
      ref_mem[5] = 64'd12;
      m_last_d = 1'b0;
      m_errcnt = 0;
      reset_n = 1'b0;
      f_req = 1'b0; f_addr = '0;
      d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;

      repeat (2) @(negedge clock);
      f_req = 1'b1; d_req = 1'b1; f_addr = 64'd5; d_addr = 64'd7;
      #1;
      chk("rst_gnt", 64'({f_gnt, d_gnt}), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_rvalid", 64'({f_rvalid, d_rvalid, f_err, d_err}), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Tie after reset goes to data, then fetch reads word 5
      run_round(1'b1, 1'b1, 64'd5, 64'd7, 1'b0, 64'd0);
      run_round(1'b1, 1'b1, 64'd5, 64'd8, 1'b0, 64'd0);
      run_round(1'b0, 1'b1, 64'd0, 64'd3, 1'b1, 64'hABCD);
      run_round(1'b1, 1'b0, 64'd3, 64'd0, 1'b0, 64'd0);
      run_round(1'b0, 1'b1, 64'd0, 64'd1024, 1'b0, 64'd0);
      run_round(1'b0, 1'b1, 64'd0, 64'd1023, 1'b0, 64'd0);
      run_round(1'b1, 1'b0, 64'd1023, 64'd0, 1'b0, 64'd0);
      run_round(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'd0);
      run_round(1'b0, 1'b1, 64'd0, 64'h1_0000_0005, 1'b1, 64'h55);

      repeat (200) begin
         int p;
         p = $urandom_range(1, 3);
         run_round(p[0], p[1], rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                   {32'($urandom), 32'($urandom)});
      end

      repeat (300) run_round(1'b0, 1'b1, 64'd0, 64'(DEPTH) + 64'($urandom_range(0, 5000)), 1'b0, 64'd0);
      chk("err_sat", 64'(err_count), 64'd255);

      // Reset during RESP_F discards the response
      f_req = 1'b1; f_addr = 64'd5;
      #1;
      chk("pre_rst_f_gnt", 64'(f_gnt), 64'd1);
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      f_req = 1'b0;
      #1;
      chk("mid_rst_rvalid", 64'({f_rvalid, d_rvalid, f_err, d_err}), 64'd0);
      chk("mid_rst_rdata", f_rdata | d_rdata, 64'd0);
      chk("mid_rst_err_count", 64'(err_count), 64'd0);
      chk("mid_rst_mem", 64'({mem_en, mem_we}), 64'd0);
      m_last_d = 1'b0;
      m_errcnt = 0;
      @(negedge clock);
      chk("mid_rst_rvalid2", 64'(f_rvalid), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      run_round(1'b1, 1'b1, 64'd2000, 64'd4, 1'b0, 64'd0);

      repeat (50) begin
         int p;
         p = $urandom_range(1, 3);
         run_round(p[0], p[1], rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                   {32'($urandom), 32'($urandom)});
      end

      repeat (2) @(negedge clock);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 64-bit memory words; legal word addresses are 0..DEPTH-1.
REQ-002 SHALL have parameter AW, default 10, memory address width, equal to clog2(DEPTH).
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port f_req, input, 1 bit, fetch-port read request, held until granted.
REQ-006 SHALL have port f_addr, input, 64 bits, fetch word address.
REQ-007 SHALL have ports f_gnt, f_rvalid and f_err, outputs, 1 bit each: grant, response valid, and out-of-range error.
REQ-008 SHALL have port f_rdata, output, 64 bits, fetch read data.
REQ-009 SHALL have port d_req, input, 1 bit, data-port request, held until granted.
REQ-010 SHALL have port d_we, input, 1 bit, data-port write enable (1 = write, 0 = read).
REQ-011 SHALL have ports d_addr and d_wdata, inputs, 64 bits each.
REQ-012 SHALL have ports d_gnt, d_rvalid and d_err, outputs, 1 bit each, and port d_rdata, output, 64 bits.
REQ-013 SHALL have ports mem_en and mem_we, outputs, 1 bit each, memory strobes.
REQ-014 SHALL have port mem_addr, output, AW bits, and port mem_wdata, output, 64 bits.
REQ-015 SHALL have port mem_rdata, input, 64 bits; the memory reads synchronously and data is valid the cycle after mem_en.
REQ-016 SHALL have port err_count, output, 8 bits, saturating count of out-of-range requests.

Function
REQ-017 SHALL implement the FSM states IDLE, RESP_F and RESP_D.
REQ-018 In IDLE with any req high, SHALL combinationally grant exactly one port: assert its gnt that cycle, then move to RESP_F or RESP_D.
REQ-019 SHALL grant no port in RESP_F or RESP_D; requests wait, so maximum throughput is one transaction per 2 cycles.
REQ-020 When both ports request in the same cycle, SHALL grant the port not granted most recently (round-robin via a last_grant register, updated on every grant).
REQ-021 SHALL assert, in a grant cycle with a legal address (addr <= DEPTH-1): mem_en=1; mem_addr = addr[AW-1:0]; mem_we = d_we for the data port and 0 for the fetch port; mem_wdata = d_wdata.
REQ-022 SHALL drive mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0 in every non-grant cycle.
REQ-023 In the cycle after a grant (RESP_x), SHALL pulse x_rvalid for exactly 1 cycle; read data = mem_rdata, write data = 0 (the pulse acknowledges the write).
REQ-024 For an illegal address (addr > DEPTH-1, all 64 bits compared), SHALL still grant but keep mem_en=0.
REQ-025 For an illegal address, SHALL then pulse x_rvalid and x_err together for 1 cycle with x_rdata=0, and increment err_count.
REQ-026 SHALL saturate err_count at 255.
REQ-027 SHALL register rvalid, err and rdata (hold rdata at 0 outside rvalid cycles) and drive gnt combinationally from state and req.
REQ-028 Every RESP state SHALL return to IDLE after 1 cycle unconditionally.
REQ-029 A request deasserted before grant SHALL be dropped with no response.

Reset
REQ-030 On reset_n=0, asynchronously: state=IDLE, last_grant=fetch (data port wins the first tie), all rvalid/err/rdata=0, err_count=0, mem strobes=0.
REQ-031 On reset assertion mid-transaction, the pending response SHALL be discarded and no rvalid issued.
REQ-032 While reset_n=0, SHALL issue no gnt.
REQ-033 After reset release, SHALL allow the first grant on the first rising edge where reset_n=1.

Verification
REQ-034 Single fetch read: f_req=1, f_addr=5, mem returns 12 -> f_gnt cycle 0 with mem_en=1, mem_addr=5; f_rvalid=1, f_rdata=12 at cycle 1.
REQ-035 Simultaneous requests after reset: f_req=d_req=1 held -> d_gnt first; f_gnt 2 cycles later; repeating -> strict alternation.
REQ-036 Data write: d_we=1, d_addr=3, d_wdata=0xABCD -> mem_we=1, mem_addr=3, mem_wdata=0xABCD; d_rvalid next cycle with d_rdata=0.
REQ-037 Out of range: d_addr=1024 -> d_gnt=1, mem_en=0; next cycle d_rvalid=d_err=1, err_count=1; 300 such requests -> err_count=255.
REQ-038 Reset in RESP_F: reset_n=0 the cycle after f_gnt -> no f_rvalid; state=IDLE; all outputs 0.
REQ-039 Back-to-back fetch: f_req held high -> f_gnt on alternate cycles, never in the same cycle as f_rvalid.
